dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port data memory (256 x 16, synchronous read, 1-cycle read latency) between two requesters: the processor control FSM (CPU port) and a host/debug loader port.
The CPU has default priority. A bounded-wait counter guarantees host progress, and a host lock allows atomic read-modify-write sequences.
The block sits between the control FSM's D_Addr/D_wr path and the data memory instance.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 16, data word width
MAX_WAIT, 4, consecutive host-denied cycles before host is granted over CPU (range 1..15)

Ports:
Clk  in  1  system clock
Reset  in  1  reset, synchronous, active-high
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  access issued to memory this cycle
cpu_rvalid  out  1  cpu_rdata valid (read issued previous cycle)
cpu_rdata  out  DATA_W  read data
host_req  in  1  host access request, held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_lock  in  1  keep ownership after current host grant
host_gnt  out  1  access issued this cycle
host_rvalid  out  1  host_rdata valid
host_rdata  out  DATA_W  read data
mem_addr  out  ADDR_W  to memory
mem_we  out  1  to memory
mem_wdata  out  DATA_W  to memory
mem_rdata  in  DATA_W  from memory, valid 1 cycle after read issue
host_owns  out  1  lock state is LOCKED

Behaviour:
- Grant is combinational from current request inputs and registered state. At most one of cpu_gnt/host_gnt is high per cycle.
- mem_addr/mem_we/mem_wdata come from the granted requester.
- With no grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Registered state:
  - lock_state: UNLOCKED / LOCKED
  - wait_cnt: 4 bits
  - rd_owner: NONE / CPU / HOST
- Reset: lock_state = UNLOCKED, wait_cnt = 0, rd_owner = NONE; all gnt/rvalid outputs 0; host_owns = 0.
- Arbitration in UNLOCKED:
  - cpu_req only -> CPU.
  - host_req only -> HOST.
  - Both -> HOST if wait_cnt >= MAX_WAIT, else CPU.
- Arbitration in LOCKED:
  - Only host is granted; cpu_req is stalled and cpu_gnt = 0.
  - If host_req is 0 in a LOCKED cycle, nothing is granted.
- wait_cnt:
  - Increments (saturating at 15) each cycle host_req = 1 and host_gnt = 0.
  - Clears on host_gnt or when host_req = 0.
- Lock transitions:
  - UNLOCKED -> LOCKED on a cycle with host_gnt = 1 and host_lock = 1.
  - LOCKED -> UNLOCKED on the first cycle host_lock = 0; that cycle already arbitrates as UNLOCKED, so lock_state is decoded combinationally with host_lock.
- Read return:
  - On a granted read (we = 0), rd_owner <= owner; otherwise rd_owner <= NONE.
  - cpu_rvalid = (rd_owner == CPU); host_rvalid = (rd_owner == HOST).
  - Both rdata outputs are wired to mem_rdata. Consumers qualify them with their rvalid.
- Latency:
  - Write completes in the grant cycle.
  - Read data is available exactly 1 cycle after the grant.
  - Back-to-back grants are allowed every cycle.
- Reset mid-operation: a pending rvalid is dropped (rd_owner cleared). A grant asserted in the reset cycle is suppressed, so mem_we = 0 while Reset = 1.
- A requester dropping req without gnt is legal; no state change except wait_cnt clear.

Decomposition:
- Package dmem_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_HOST}
  - lock_t enum {UNLOCKED, LOCKED}
  - ADDR_W/DATA_W defaults
- One natural sub-module: arb_wait_counter (saturating 4-bit counter with inc/clr and the >= MAX_WAIT compare).

Test Plan:
- CPU read only, cpu_addr = 8'h09, mem holds 16'h1234 -> cpu_gnt in cycle N, cpu_rvalid = 1 with cpu_rdata = 16'h1234 in N+1, host outputs 0.
- Host write addr 8'h10, data 16'hBEEF, then CPU read 8'h10 -> host_gnt cycle N with mem_we = 1; CPU read returns 16'hBEEF.
- cpu_req and host_req held high continuously, MAX_WAIT = 4 -> CPU granted 4 cycles, host granted on 5th, then pattern repeats (4 CPU : 1 host).
- Host grant with host_lock = 1, CPU requesting, host issues 3 accesses with lock held -> cpu_gnt = 0 throughout, host_owns = 1; host_lock drops -> CPU granted that same cycle.
- Reset asserted cycle after a CPU read grant -> cpu_rvalid = 0, mem_we = 0, wait_cnt = 0, host_owns = 0 next cycle.
- Neither requesting -> no gnt, mem_we = 0, no rvalid for two subsequent cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int WAIT_W     = 4;

    // Who owns the read data returning from memory this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    // Host atomic-sequence lock.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive host-denied cycles, with the starvation compare.
// Latency: count updates on the clock edge; expired is combinational from the count.
// Backpressure: none; clr has priority over inc.
//
// Ports: Clk, Reset (sync, active-high); inc/clr controls; expired = count >= MAX_WAIT.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WAIT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt >= WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU FSM and the host loader.
// Latency: grant and write are combinational in the request cycle; read data returns 1 cycle after grant.
// Backpressure: a requester holds req until gnt; CPU wins by default, host wins after MAX_WAIT denials or while locked.
//
// Ports: cpu_* and host_* request/grant/read-return channels, mem_* drive the memory,
// host_owns reflects the registered lock state. Clk, Reset (sync, active-high).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              host_owns
);

    lock_t  lock_state, lock_nxt;
    owner_t rd_owner, rd_nxt;
    owner_t own;
    logic   lock_eff;
    logic   wait_expired;
    logic   wait_inc;

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .Clk     (Clk),
        .Reset   (Reset),
        .inc     (wait_inc),
        .clr     (!wait_inc),
        .expired (wait_expired)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lock_state <= UNLOCKED;
            rd_owner   <= OWN_NONE;
        end else begin
            lock_state <= lock_nxt;
            rd_owner   <= rd_nxt;
        end
    end

    always_comb begin
        own       = OWN_NONE;
        lock_nxt  = lock_state;
        rd_nxt    = OWN_NONE;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;

        // Releasing host_lock takes effect in the same cycle, so the CPU can
        // win the very cycle the host lets go.
        lock_eff = (lock_state == LOCKED) && host_lock;

        if (Reset) begin
            own = OWN_NONE;
        end else if (lock_eff) begin
            own = host_req ? OWN_HOST : OWN_NONE;
        end else if (cpu_req && host_req) begin
            own = wait_expired ? OWN_HOST : OWN_CPU;
        end else if (cpu_req) begin
            own = OWN_CPU;
        end else if (host_req) begin
            own = OWN_HOST;
        end

        if (own == OWN_CPU) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
            rd_nxt    = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (own == OWN_HOST) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
            rd_nxt    = host_we ? OWN_NONE : OWN_HOST;
        end

        if ((own == OWN_HOST) && host_lock) begin
            lock_nxt = LOCKED;
        end else if (!host_lock) begin
            lock_nxt = UNLOCKED;
        end
    end

    assign cpu_gnt  = (own == OWN_CPU);
    assign host_gnt = (own == OWN_HOST);
    assign wait_inc = host_req && !host_gnt;

    // A read return pending across a reset is dropped.
    assign cpu_rvalid  = !Reset && (rd_owner == OWN_CPU);
    assign host_rvalid = !Reset && (rd_owner == OWN_HOST);
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign host_owns   = (lock_state == LOCKED);

endmodule
